// File: rtl/word3_ser_pkg.sv
// ============================================================================
// Module      : word3_ser_pkg
// Description : Shared state encoding and beat-index constants for
//               word3_serializer.  Optional checksum beat: WORD3_SER_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package word3_ser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_B0   = 3'd1,
      ST_B1   = 3'd2,
      ST_B2   = 3'd3,
      ST_CHK  = 3'd4
   } state_t;

   localparam logic [1:0] IDX_B0  = 2'd0;
   localparam logic [1:0] IDX_B1  = 2'd1;
   localparam logic [1:0] IDX_B2  = 2'd2;
   localparam logic [1:0] IDX_CHK = 2'd3;

endpackage

`default_nettype wire

// File: rtl/word3_ser_ctrl.sv
// ============================================================================
// Module      : word3_ser_ctrl
// Description : Beat sequencer for word3_serializer; owns the state machine
//               and the registered valid/index/last outputs.
//               Optional checksum beat: WORD3_SER_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word3_ser_ctrl
   import word3_ser_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_in_valid,
   input  logic       i_out_ready,
   output logic       o_in_ready,
   output logic       o_busy,
   output logic       o_out_valid,
   output logic [1:0] o_out_index,
   output logic       o_out_last
);

   state_t     r_state;
   logic       r_out_valid;
   logic [1:0] r_out_index;
   logic       r_out_last;

   // Outputs are updated together with the state so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_out_index <= IDX_B0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_in_valid) begin
                  r_state     <= ST_B0;
                  r_out_valid <= 1'b1;
                  r_out_index <= IDX_B0;
                  r_out_last  <= 1'b0;
               end
            end
            ST_B0: begin
               if (i_out_ready) begin
                  r_state     <= ST_B1;
                  r_out_index <= IDX_B1;
               end
            end
            ST_B1: begin
               if (i_out_ready) begin
                  r_state     <= ST_B2;
                  r_out_index <= IDX_B2;
`ifdef WORD3_SER_CHKSUM_EN
                  r_out_last  <= 1'b0;
`else
                  r_out_last  <= 1'b1;
`endif
               end
            end
            ST_B2: begin
               if (i_out_ready) begin
`ifdef WORD3_SER_CHKSUM_EN
                  r_state     <= ST_CHK;
                  r_out_index <= IDX_CHK;
                  r_out_last  <= 1'b1;
`else
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_out_index <= IDX_B0;
                  r_out_last  <= 1'b0;
`endif
               end
            end
`ifdef WORD3_SER_CHKSUM_EN
            ST_CHK: begin
               if (i_out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_out_index <= IDX_B0;
                  r_out_last  <= 1'b0;
               end
            end
`endif
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_out_index <= IDX_B0;
               r_out_last  <= 1'b0;
            end
         endcase
      end
   end

   assign o_in_ready  = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_out_valid = r_out_valid;
   assign o_out_index = r_out_index;
   assign o_out_last  = r_out_last;

endmodule

`default_nettype wire

// File: rtl/word3_serializer.sv
// ============================================================================
// Module      : word3_serializer
// Description : Captures a three-word bundle and emits it as ready/valid beats.
//               Optional XOR checksum beat: WORD3_SER_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module word3_serializer
   import word3_ser_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_in_1,
   input  logic [WIDTH-1:0] i_in_2,
   input  logic [WIDTH-1:0] i_in_3,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_out_data,
   output logic [1:0]       o_out_index,
   output logic             o_out_last,
   output logic             o_busy
);

   logic             w_in_ready;
   logic             w_out_valid;
   logic [1:0]       w_out_index;
   logic             w_capture;
   logic [WIDTH-1:0] w_out_data;
   logic [WIDTH-1:0] r_word1;
   logic [WIDTH-1:0] r_word2;
   logic [WIDTH-1:0] r_word3;

   word3_ser_ctrl u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .i_out_ready (i_out_ready),
      .o_in_ready  (w_in_ready),
      .o_busy      (o_busy),
      .o_out_valid (w_out_valid),
      .o_out_index (w_out_index),
      .o_out_last  (o_out_last)
   );

   assign w_capture = i_in_valid && w_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word1 <= '0;
         r_word2 <= '0;
         r_word3 <= '0;
      end else if (w_capture) begin
         r_word1 <= i_in_1;
         r_word2 <= i_in_2;
         r_word3 <= i_in_3;
      end
   end

   // Gated by valid so the bus reads zero while idle.
   always_comb begin
      w_out_data = '0;
      if (w_out_valid) begin
         case (w_out_index)
            IDX_B0:  w_out_data = r_word1;
            IDX_B1:  w_out_data = r_word2;
            IDX_B2:  w_out_data = r_word3;
`ifdef WORD3_SER_CHKSUM_EN
            IDX_CHK: w_out_data = r_word1 ^ r_word2 ^ r_word3;
`endif
            default: w_out_data = '0;
         endcase
      end
   end

   assign o_in_ready  = w_in_ready;
   assign o_out_valid = w_out_valid;
   assign o_out_index = w_out_index;
   assign o_out_data  = w_out_data;

endmodule

`default_nettype wire

// File: tb/tb_word3_serializer.sv
// ============================================================================
// Module      : tb_word3_serializer
// Description : Scoreboard bench for word3_serializer (either build of
//               WORD3_SER_CHKSUM_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_word3_serializer;

`ifdef WORD3_SER_CHKSUM_EN
   localparam int NBEATS = 4;
`else
   localparam int NBEATS = 3;
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  idx;
      logic        last;
   } beat_t;

   logic        clk;
   logic        rst_n;
   logic        i_in_valid;
   logic        o_in_ready;
   logic [31:0] i_in_1;
   logic [31:0] i_in_2;
   logic [31:0] i_in_3;
   logic        o_out_valid;
   logic        i_out_ready;
   logic [31:0] o_out_data;
   logic [1:0]  o_out_index;
   logic        o_out_last;
   logic        o_busy;

   int    n_cmp = 0;
   int    n_err = 0;
   beat_t sb[$];
   bit    exp_idle = 1'b0;

   word3_serializer #(.WIDTH(32)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_in_valid  (i_in_valid),
      .o_in_ready  (o_in_ready),
      .i_in_1      (i_in_1),
      .i_in_2      (i_in_2),
      .i_in_3      (i_in_3),
      .o_out_valid (o_out_valid),
      .i_out_ready (i_out_ready),
      .o_out_data  (o_out_data),
      .o_out_index (o_out_index),
      .o_out_last  (o_out_last),
      .o_busy      (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Scoreboard: expected beats pushed at capture, popped at each consumed beat.
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         exp_idle = 1'b0;
      end else begin
         if (exp_idle) begin
            check("idle_after_last", {31'd0, o_in_ready}, 32'd1);
            exp_idle = 1'b0;
         end
         if (o_out_valid && i_out_ready) begin
            if (sb.size() == 0) begin
               check("extra_beat", {31'd0, o_out_valid}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("beat_data", o_out_data, e.data);
               check("beat_idx", {30'd0, o_out_index}, {30'd0, e.idx});
               check("beat_last", {31'd0, o_out_last}, {31'd0, e.last});
               if (e.last) exp_idle = 1'b1;
            end
         end
         if (i_in_valid && o_in_ready) begin
            sb.push_back('{i_in_1, 2'd0, 1'b0});
            sb.push_back('{i_in_2, 2'd1, 1'b0});
            sb.push_back('{i_in_3, 2'd2, (NBEATS == 3)});
            if (NBEATS == 4) sb.push_back('{i_in_1 ^ i_in_2 ^ i_in_3, 2'd3, 1'b1});
         end
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      int   n;
      logic ok;
      n = 0;
      i_in_valid = 1'b1;
      i_in_1 = a;
      i_in_2 = b;
      i_in_3 = c;
      do begin
         ok = o_in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 50);
      if (!ok) check("capture_timeout", {31'd0, o_in_ready}, 32'd1);
      i_in_valid = 1'b0;
      i_in_1 = $urandom();
      i_in_2 = $urandom();
      i_in_3 = $urandom();
      check("lat_valid", {31'd0, o_out_valid}, 32'd1);
      check("lat_idx", {30'd0, o_out_index}, 32'd0);
      check("lat_data", o_out_data, a);
   endtask

   task automatic drain(input bit rnd, output int cycles);
      cycles = 0;
      while (cycles < 200 && !(sb.size() == 0 && o_in_ready)) begin
         if (rnd) i_out_ready = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         cycles++;
      end
      if (cycles >= 200) check("drain_timeout", sb.size(), 32'd0);
      i_out_ready = 1'b1;
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0;
      i_in_valid = 1'b0;
      i_in_1 = '0;
      i_in_2 = '0;
      i_in_3 = '0;
      i_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, o_out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, o_in_ready}, 32'd1);
      check("rst_busy", {31'd0, o_busy}, 32'd0);
      check("rst_data", o_out_data, 32'd0);
      check("rst_idx", {30'd0, o_out_index}, 32'd0);
      check("rst_last", {31'd0, o_out_last}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Back-to-back beats with the consumer always ready.
      send(32'h11111111, 32'h22222222, 32'h33333333);
      check("busy_active", {31'd0, o_busy}, 32'd1);
      drain(1'b0, cyc);
      check("b2b_cycles", cyc, NBEATS);
      check("idle_data", o_out_data, 32'd0);

      // Backpressure held during beat index 1.
      send(32'h11111111, 32'h22222222, 32'h33333333);
      @(posedge clk);
      #1;
      i_out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("hold_data", o_out_data, 32'h22222222);
         check("hold_idx", {30'd0, o_out_index}, 32'd1);
         check("hold_last", {31'd0, o_out_last}, 32'd0);
      end
      i_out_ready = 1'b1;
      drain(1'b0, cyc);

      // New bundle offered mid-bundle must wait for IDLE.
      send(32'h44444444, 32'h55555555, 32'h66666666);
      check("busy_ready_low", {31'd0, o_in_ready}, 32'd0);
      send(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
      drain(1'b0, cyc);

      // Reset during beat index 1 drops the rest of the bundle.
      send(32'h77777777, 32'h88888888, 32'h99999999);
      @(posedge clk);
      #1;
      check("pre_rst_idx", {30'd0, o_out_index}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, o_out_valid}, 32'd0);
      check("arst_data", o_out_data, 32'd0);
      check("arst_busy", {31'd0, o_busy}, 32'd0);
      check("arst_last", {31'd0, o_out_last}, 32'd0);
      sb.delete();
      i_in_valid = 1'b1;
      i_in_1 = 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      #1;
      check("rst_no_capture", {31'd0, o_out_valid}, 32'd0);
      i_in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F);
      drain(1'b0, cyc);

      // Checksum-pattern bundle, then random backpressure.
      send(32'h0000000F, 32'h000000F0, 32'h00000F00);
      drain(1'b0, cyc);
      for (int k = 0; k < 4; k++) begin
         send($urandom(), $urandom(), $urandom());
         drain(1'b1, cyc);
      end
      check("sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
